// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch 7-segment display path.
// Segment patterns are {g,f,e,d,c,b,a}, active-high before any pin inversion.
package stopwatch_pkg;

  localparam int NUM_DIGITS = 6;

  localparam int MIN_MAX    = 59;
  localparam int SEC_MAX    = 59;
  localparam int SUBSEC_MAX = 99;

  typedef logic [2:0] digit_t;

  localparam digit_t LAST_DIGIT = digit_t'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] subsec;
  } snap_t;

  function automatic logic snap_illegal(snap_t s);
    return (s.min > 6'(MIN_MAX)) || (s.sec > 6'(SEC_MAX)) ||
           (s.subsec > 7'(SUBSEC_MAX));
  endfunction

endpackage

// File: rtl/stopwatch_display_seg7_decode.sv
// BCD digit to 7-segment pattern. Error forces a dash and wins over blanking;
// codes above 9 fall through to blank.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       error,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (error) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      for (int i = 0; i < 10; i++) begin
        if (bcd == 4'(i)) seg = SEG_DIGIT[i];
      end
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// Six-digit multiplexed MM.SS.CC display driver. A snapshot of the stopwatch
// fields is taken once per scan frame so a frame never mixes two time values.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] subsec,
  input  logic       hold,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  digit_t           digit;
  snap_t            snap;
  logic             boundary;

  assign boundary = (div_cnt == CNT_LAST) && (digit == LAST_DIGIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      digit      <= '0;
      snap       <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (div_cnt == CNT_LAST) begin
        div_cnt <= '0;
        digit   <= (digit == LAST_DIGIT) ? digit_t'(0) : digit + digit_t'(1);
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
      // Hold only matters at the frame boundary; mid-frame changes are ignored.
      if (boundary && !hold) begin
        snap.min    <= min;
        snap.sec    <= sec;
        snap.subsec <= subsec;
      end
      frame_tick <= boundary;
    end
  end

  logic [6:0] field;
  logic [3:0] bcd;
  logic       error;
  logic       lz_blank;
  logic [6:0] seg_pat;

  always_comb begin
    field = '0;
    case (digit)
      3'd0, 3'd1: field = {1'b0, snap.min};
      3'd2, 3'd3: field = {1'b0, snap.sec};
      default:    field = snap.subsec;
    endcase
  end

  // Even digits show the tens, odd digits the units of their field.
  assign bcd      = digit[0] ? 4'(field % 7'd10) : 4'(field / 7'd10);
  assign error    = snap_illegal(snap);
  assign lz_blank = (BLANK_LZ != 0) && (digit == digit_t'(0)) && (bcd == 4'd0);

  seg7_decode u_seg7_decode (
    .bcd   (bcd),
    .blank (lz_blank),
    .error (error),
    .seg   (seg_pat)
  );

  logic       slot_active;
  logic [5:0] an_pre;
  logic [6:0] seg_pre;
  logic       dp_pre;

  // Slot 0 of every digit is dark so the previous digit cannot ghost.
  assign slot_active = (div_cnt != '0);

  always_comb begin
    an_pre = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_pre[i] = slot_active && (digit == digit_t'(i));
    end
  end

  assign seg_pre = slot_active ? seg_pat : SEG_BLANK;
  assign dp_pre  = slot_active && !error &&
                   ((digit == digit_t'(1)) || (digit == digit_t'(3)));

  assign seg = (SEG_ACTIVE_LOW != 0) ? ~seg_pre : seg_pre;
  assign dp  = (SEG_ACTIVE_LOW != 0) ? ~dp_pre  : dp_pre;
  assign an  = (SEG_ACTIVE_LOW != 0) ? ~an_pre  : an_pre;

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench: stimulus queues the expected content of each upcoming frame,
// a monitor pops one entry per frame_tick and checks every scan cycle of it.
module tb_stopwatch_display;

  localparam int SCAN_DIV = 4;
  localparam int FRAME_CYC = 6 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] min;
  logic [5:0] sec;
  logic [6:0] subsec;
  logic       hold;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_tick;

  stopwatch_display #(
    .SCAN_DIV       (SCAN_DIV),
    .BLANK_LZ       (1),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .min        (min),
    .sec        (sec),
    .subsec     (subsec),
    .hold       (hold),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0][6:0] segs;
    logic [5:0]      dpm;
  } frame_t;

  frame_t sb[$];
  int n_pass  = 0;
  int n_total = 0;
  int fno     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [6:0] s0, s1, s2, s3, s4, s5, input bit err);
    frame_t f;
    f.segs[0] = s0; f.segs[1] = s1; f.segs[2] = s2;
    f.segs[3] = s3; f.segs[4] = s4; f.segs[5] = s5;
    f.dpm = err ? 6'b000000 : 6'b001010;
    sb.push_back(f);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (frame_tick) break;
      if (n >= 3 * FRAME_CYC) begin
        n_total++;
        $display("FAIL wait_tick: no frame_tick after %0d cycles, expected within %0d", n, FRAME_CYC);
        break;
      end
    end
    #2;
  endtask

  // Monitor
  initial begin
    frame_t cur;
    forever begin
      @(negedge clk);
      if (!reset && frame_tick && sb.size() > 0) begin
        cur = sb.pop_front();
        fno++;
        for (int c = 0; c < FRAME_CYC; c++) begin
          int d, s;
          logic [5:0] e_an;
          logic [6:0] e_seg;
          logic       e_dp;
          if (c > 0) @(negedge clk);
          d = c / SCAN_DIV;
          s = c % SCAN_DIV;
          e_an  = (s == 0) ? 6'b0 : 6'(1 << d);
          e_seg = (s == 0) ? 7'h00 : cur.segs[d];
          e_dp  = (s == 0) ? 1'b0 : cur.dpm[d];
          check($sformatf("frame%0d_cyc%0d", fno, c),
                {17'b0, an, seg, dp, frame_tick},
                {17'b0, e_an, e_seg, e_dp, (c == 0)});
        end
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int n;
    reset = 1'b1; hold = 1'b0;
    min = 6'd12; sec = 6'd34; subsec = 7'd56;
    repeat (3) @(negedge clk);
    check("reset_state", {an, seg, dp, frame_tick}, 15'h0);
    reset = 1'b0;
    repeat (14) @(negedge clk);
    check("scan_digit3", an, 6'b001000);
    #2 reset = 1'b1;
    #1 check("async_reset", {an, seg, dp, frame_tick}, 15'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("post_release_blank", an, 6'b000000);
    @(negedge clk);
    check("first_slot", an, 6'b000001);

    push(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 0);          // 12:34.56
    wait_tick(n);
    check("first_tick_edge", n + 1, 24);

    min = 6'd5; sec = 6'd0; subsec = 7'd7;
    push(7'h00, 7'h6D, 7'h3F, 7'h3F, 7'h3F, 7'h07, 0);          // 05:00.07 blanked
    wait_tick(n);

    min = 6'd1; sec = 6'd2; subsec = 7'd3;
    push(7'h00, 7'h06, 7'h3F, 7'h5B, 7'h3F, 7'h4F, 0);          // 01:02.03
    wait_tick(n);

    repeat (5) @(negedge clk);
    hold = 1'b1;
    min = 6'd40; sec = 6'd40; subsec = 7'd40;
    repeat (3) push(7'h00, 7'h06, 7'h3F, 7'h5B, 7'h3F, 7'h4F, 0);
    repeat (3) wait_tick(n);

    hold = 1'b0;
    push(7'h66, 7'h3F, 7'h66, 7'h3F, 7'h66, 7'h3F, 0);          // 40:40.40
    wait_tick(n);

    min = 6'd60;
    push(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 1);          // error dashes
    wait_tick(n);

    min = 6'd59;
    push(7'h6D, 7'h6F, 7'h66, 7'h3F, 7'h66, 7'h3F, 0);          // 59:40.40
    wait_tick(n);

    subsec = 7'd99;
    repeat (23) @(negedge clk);
    subsec = 7'd0;
    push(7'h6D, 7'h6F, 7'h66, 7'h3F, 7'h3F, 7'h3F, 0);          // 59:40.00
    wait_tick(n);

    repeat (8) @(negedge clk);
    subsec = 7'd1;
    push(7'h6D, 7'h6F, 7'h66, 7'h3F, 7'h3F, 7'h06, 0);          // 59:40.01
    wait_tick(n);

    repeat (FRAME_CYC + 2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
